// File: rtl/ccc_reconfig_ctrl.sv
`timescale 1ns/1ps
// CCC/PLL reconfiguration sequencer: applies a host-loaded (addr, data) table over a
// zero-wait APB port while holding the PLL in reset, then waits for lock with bounded retry.
module ccc_reconfig_ctrl #(
    parameter int NUM_ENTRIES  = 8,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRIES  = 2,
    parameter int VERIFY       = 1,
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
    input  logic          PCLK,
    input  logic          PRESET_N,
    input  logic          TBL_WE,
    input  logic [IW-1:0] TBL_IDX,
    input  logic [5:0]    TBL_ADDR,
    input  logic [7:0]    TBL_DATA,
    input  logic [CW-1:0] TBL_COUNT,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERROR,
    output logic [1:0]    ERR_CODE,
    output logic          LOCK_OK,
    output logic          LOCK_LOST,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [5:0]    PADDR,
    output logic [7:0]    PWDATA,
    input  logic [7:0]    PRDATA,
    input  logic          CCC_LOCK,
    output logic          PLL_ARST_N
);
    localparam int TMAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_W_SETUP, S_W_ACCESS, S_R_SETUP, S_R_ACCESS,
        S_NEXT, S_RELEASE, S_WAIT_LOCK, S_SUCCESS, S_FAIL
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [5:0]             r_tbl_addr [NUM_ENTRIES];
    logic [7:0]             r_tbl_data [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_tbl_we;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          r_idx;
    logic [CW-1:0]          w_idx_inc;
    logic [CW-1:0]          w_count_sat;
    logic [IW-1:0]          w_rd_sel;
    logic [TW-1:0]          r_timer;
    logic [RW-1:0]          r_retry;
    logic                   r_lock_meta;
    logic                   r_lock_sync;
    logic                   r_lock_d;
    logic                   r_error;
    logic [1:0]             r_err_code;
    logic                   r_lock_lost;
    logic [5:0]             r_paddr;
    logic [7:0]             r_pwdata;
    logic                   w_start_ok;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_tbl_we
            assign w_tbl_we[gi] = TBL_WE && !BUSY && (TBL_IDX == IW'(gi));
        end
    endgenerate

    assign w_start_ok  = (r_state == S_IDLE) && START;
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_count_sat = (TBL_COUNT > CW'(NUM_ENTRIES)) ? CW'(NUM_ENTRIES) : TBL_COUNT;
    // Entry about to be presented: the next one when leaving NEXT, else the current one.
    assign w_rd_sel    = IW'((r_state == S_NEXT) ? w_idx_inc : r_idx);

    assign ERROR     = r_error;
    assign ERR_CODE  = r_err_code;
    assign LOCK_OK   = r_lock_sync;
    assign LOCK_LOST = r_lock_lost;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

    always_comb begin
        w_state_next = r_state;
        BUSY         = 1'b1;
        DONE         = 1'b0;
        PSEL         = 1'b0;
        PENABLE      = 1'b0;
        PWRITE       = 1'b0;
        PLL_ARST_N   = 1'b1;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) w_state_next = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                PLL_ARST_N = 1'b0;
                if (r_timer == TW'(RST_CYCLES - 1))
                    w_state_next = (r_count != '0) ? S_W_SETUP : S_RELEASE;
            end
            S_W_SETUP: begin
                PLL_ARST_N   = 1'b0;
                PSEL         = 1'b1;
                PWRITE       = 1'b1;
                w_state_next = S_W_ACCESS;
            end
            S_W_ACCESS: begin
                PLL_ARST_N   = 1'b0;
                PSEL         = 1'b1;
                PENABLE      = 1'b1;
                PWRITE       = 1'b1;
                w_state_next = (VERIFY != 0) ? S_R_SETUP : S_NEXT;
            end
            S_R_SETUP: begin
                PLL_ARST_N   = 1'b0;
                PSEL         = 1'b1;
                w_state_next = S_R_ACCESS;
            end
            S_R_ACCESS: begin
                PLL_ARST_N   = 1'b0;
                PSEL         = 1'b1;
                PENABLE      = 1'b1;
                w_state_next = (PRDATA == r_pwdata) ? S_NEXT : S_FAIL;
            end
            S_NEXT: begin
                PLL_ARST_N   = 1'b0;
                w_state_next = (w_idx_inc < r_count) ? S_W_SETUP : S_RELEASE;
            end
            S_RELEASE: w_state_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (r_lock_sync)
                    w_state_next = S_SUCCESS;
                else if (r_timer == TW'(LOCK_TIMEOUT))
                    w_state_next = (r_retry < RW'(MAX_RETRIES)) ? S_RST_HOLD : S_FAIL;
            end
            S_SUCCESS: begin
                BUSY         = 1'b0;
                DONE         = 1'b1;
                w_state_next = S_IDLE;
            end
            S_FAIL: begin
                BUSY         = 1'b0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_retry     <= '0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_lock_d    <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_lock_lost <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_tbl_addr[i] <= '0;
                r_tbl_data[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_lock_meta <= CCC_LOCK;
            r_lock_sync <= r_lock_meta;
            r_lock_d    <= r_lock_sync;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_tbl_we[i]) begin
                    r_tbl_addr[i] <= TBL_ADDR;
                    r_tbl_data[i] <= TBL_DATA;
                end
            end
            // One timer serves both the reset hold and the lock wait; it restarts on every state change.
            if (r_state == S_IDLE || w_state_next != r_state)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
            if (w_start_ok) begin
                r_count     <= w_count_sat;
                r_idx       <= '0;
                r_retry     <= '0;
                r_error     <= 1'b0;
                r_err_code  <= 2'b00;
                r_lock_lost <= 1'b0;
            end else if (r_state == S_IDLE && r_lock_d && !r_lock_sync) begin
                r_lock_lost <= 1'b1;
            end
            if (r_state == S_NEXT)
                r_idx <= w_idx_inc;
            if (r_state == S_WAIT_LOCK && w_state_next == S_RST_HOLD) begin
                r_retry <= r_retry + 1'b1;
                r_idx   <= '0;
            end
            if (w_state_next == S_FAIL) begin
                r_error    <= 1'b1;
                r_err_code <= (r_state == S_R_ACCESS) ? 2'b01 : 2'b10;
            end
            if (w_state_next == S_W_SETUP) begin
                r_paddr  <= r_tbl_addr[w_rd_sel];
                r_pwdata <= r_tbl_data[w_rd_sel];
            end
        end
    end
endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ccc_reconfig_ctrl: a table of whole-sequence scenarios with
// hand-computed cycle counts, plus hand sequences for lock loss and mid-write reset.
module tb_ccc_reconfig_ctrl;
    localparam int NE = 8;

    typedef struct {
        int count;
        int lock_delay;
        bit bad_en;
        int bad_entry;
        bit poke;
        int exp_end;
        bit exp_done;
        bit exp_err;
        int exp_code;
        int exp_wr;
        int exp_rd;
        int exp_rst_low;
        int exp_passes;
        int exp_psel;
    } vec_t;

    logic       PCLK, PRESET_N, TBL_WE, START;
    logic [2:0] TBL_IDX;
    logic [5:0] TBL_ADDR;
    logic [7:0] TBL_DATA;
    logic [3:0] TBL_COUNT;
    logic       BUSY, DONE, ERROR, LOCK_OK, LOCK_LOST;
    logic [1:0] ERR_CODE;
    logic       PSEL, PENABLE, PWRITE, PLL_ARST_N, CCC_LOCK;
    logic [5:0] PADDR;
    logic [7:0] PWDATA, PRDATA;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] exp_addr [NE];
    logic [7:0] exp_data [NE];
    logic [7:0] ccc_mem  [64];
    vec_t       vecs [6];

    ccc_reconfig_ctrl #(
        .NUM_ENTRIES(NE), .RST_CYCLES(16), .LOCK_TIMEOUT(100), .MAX_RETRIES(2), .VERIFY(1)
    ) dut (
        .PCLK(PCLK), .PRESET_N(PRESET_N), .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX),
        .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA), .TBL_COUNT(TBL_COUNT), .START(START),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE), .LOCK_OK(LOCK_OK),
        .LOCK_LOST(LOCK_LOST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .CCC_LOCK(CCC_LOCK),
        .PLL_ARST_N(PLL_ARST_N)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_snapshot();
        return {7'd0, BUSY, DONE, ERROR, ERR_CODE, LOCK_OK, LOCK_LOST, PSEL, PENABLE,
                PWRITE, PADDR, PWDATA, PLL_ARST_N};
    endfunction

    function automatic vec_t mk(int count, int dly, bit bad_en, int bad_entry, bit poke,
                                int e_end, bit e_done, bit e_err, int e_code, int e_wr,
                                int e_rd, int e_rst, int e_pass, int e_psel);
        vec_t v;
        v.count = count;   v.lock_delay = dly;  v.bad_en = bad_en;
        v.bad_entry = bad_entry; v.poke = poke; v.exp_end = e_end;
        v.exp_done = e_done; v.exp_err = e_err; v.exp_code = e_code;
        v.exp_wr = e_wr;   v.exp_rd = e_rd;     v.exp_rst_low = e_rst;
        v.exp_passes = e_pass; v.exp_psel = e_psel;
        return v;
    endfunction

    // Cycle 1 is the first cycle after the edge that samples START.
    task automatic run_vec(input int id, input vec_t v);
        int         cyc = 1;
        int         n_wr = 0, n_rd = 0, n_setup = 0, rst_low = 0, passes = 0;
        int         first_psel = 0, end_cyc = 0, rel_cyc = 0, viol = 0, cnt_eff;
        logic       prev_arst = 1'b1;
        logic       done_end = 1'b0, err_end = 1'b0;
        logic [1:0] code_end = 2'b00;
        logic [5:0] bad_addr;
        cnt_eff   = (v.count > NE) ? NE : v.count;
        bad_addr  = exp_addr[v.bad_entry];
        TBL_COUNT = 4'(v.count);
        START     = 1'b1;
        @(negedge PCLK);
        START = 1'b0;
        check($sformatf("v%0d_c1_busy", id), BUSY, 1);
        check($sformatf("v%0d_c1_cleared", id), {LOCK_LOST, ERROR, ERR_CODE}, 0);
        while (end_cyc == 0 && cyc < 2000) begin
            if (!PLL_ARST_N) rst_low++;
            if (prev_arst && !PLL_ARST_N) passes++;
            if (!prev_arst && PLL_ARST_N) rel_cyc = cyc;
            if (PSEL && first_psel == 0) first_psel = cyc;
            if ((PSEL && PLL_ARST_N) || (PENABLE && !PSEL)) viol++;
            if (PSEL && !PENABLE) n_setup++;
            if (PSEL && PENABLE && PWRITE) begin
                if (cnt_eff > 0) begin
                    check($sformatf("v%0d_wr%0d_addr", id, n_wr), PADDR, exp_addr[n_wr % cnt_eff]);
                    check($sformatf("v%0d_wr%0d_data", id, n_wr), PWDATA, exp_data[n_wr % cnt_eff]);
                end
                ccc_mem[PADDR] = PWDATA;
                n_wr++;
            end
            if (PSEL && PENABLE && !PWRITE) n_rd++;
            if (!BUSY) begin
                end_cyc  = cyc;
                done_end = DONE;
                err_end  = ERROR;
                code_end = ERR_CODE;
            end
            PRDATA = ccc_mem[PADDR] ^ ((v.bad_en && PADDR == bad_addr) ? 8'h01 : 8'h00);
            if (!PLL_ARST_N)
                CCC_LOCK = 1'b0;
            else if (v.lock_delay >= 0 && rel_cyc > 0 && cyc - rel_cyc >= v.lock_delay)
                CCC_LOCK = 1'b1;
            if (v.poke && cyc == 5) begin
                TBL_WE = 1'b1; TBL_IDX = 3'd0; TBL_ADDR = 6'h3F; TBL_DATA = 8'hEE;
            end
            if (v.poke && cyc == 20) START = 1'b1;
            prev_arst = PLL_ARST_N;
            @(negedge PCLK);
            TBL_WE = 1'b0;
            START  = 1'b0;
            cyc++;
        end
        check($sformatf("v%0d_end_cycle", id), end_cyc, v.exp_end);
        check($sformatf("v%0d_done", id), done_end, v.exp_done);
        check($sformatf("v%0d_error", id), err_end, v.exp_err);
        check($sformatf("v%0d_err_code", id), code_end, v.exp_code);
        check($sformatf("v%0d_writes", id), n_wr, v.exp_wr);
        check($sformatf("v%0d_reads", id), n_rd, v.exp_rd);
        check($sformatf("v%0d_setups", id), n_setup, v.exp_wr + v.exp_rd);
        check($sformatf("v%0d_rst_low", id), rst_low, v.exp_rst_low);
        check($sformatf("v%0d_rst_passes", id), passes, v.exp_passes);
        check($sformatf("v%0d_first_psel", id), first_psel, v.exp_psel);
        check($sformatf("v%0d_apb_viol", id), viol, 0);
        check($sformatf("v%0d_after_done", id), DONE, 0);
        check($sformatf("v%0d_after_err", id), {ERROR, ERR_CODE}, {v.exp_err, 2'(v.exp_code)});
        check($sformatf("v%0d_after_arst", id), PLL_ARST_N, 1);
        $display("vec %0d: count=%0d end=%0d wr=%0d rd=%0d done=%0b err=%0b code=%0d",
                 id, v.count, end_cyc, n_wr, n_rd, done_end, err_end, code_end);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ccc_mem[i] = 8'h00;
        //              cnt dly bad ent poke  end done err code wr rd rstlow pass psel
        vecs[0] = mk(3,  10, 0, 0, 0,   45, 1, 0, 0, 3, 3, 31, 1, 17);
        vecs[1] = mk(3,  10, 1, 1, 0,   26, 0, 1, 1, 2, 2, 25, 1, 17);
        vecs[2] = mk(2,  -1, 0, 0, 0,  385, 0, 1, 2, 6, 6, 78, 3, 17);
        vecs[3] = mk(3,  10, 0, 0, 1,   45, 1, 0, 0, 3, 3, 31, 1, 17);
        vecs[4] = mk(0,   5, 0, 0, 0,   25, 1, 0, 0, 0, 0, 16, 1, 0);
        vecs[5] = mk(10,  0, 0, 0, 0,   60, 1, 0, 0, 8, 8, 56, 1, 17);

        PRESET_N = 1'b0; TBL_WE = 1'b0; START = 1'b0; TBL_IDX = '0; TBL_ADDR = '0;
        TBL_DATA = '0; TBL_COUNT = '0; PRDATA = '0; CCC_LOCK = 1'b0;
        repeat (3) @(negedge PCLK);
        check("reset_outputs", out_snapshot(), 32'h1);
        PRESET_N = 1'b1;
        @(negedge PCLK);

        for (int i = 0; i < NE; i++) begin
            exp_addr[i] = 6'(8 + 5 * i);
            exp_data[i] = 8'(8'h3C ^ (i * 29));
            TBL_WE = 1'b1; TBL_IDX = 3'(i); TBL_ADDR = exp_addr[i]; TBL_DATA = exp_data[i];
            @(negedge PCLK);
        end
        TBL_WE = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        // Idle lock loss: LOCK_OK lags by two cycles, the sticky flag follows one cycle later.
        repeat (2) @(negedge PCLK);
        check("lost_pre_lock_ok", LOCK_OK, 1);
        check("lost_pre_flag", LOCK_LOST, 0);
        CCC_LOCK = 1'b0;
        @(negedge PCLK);
        check("lost_t1_lock_ok", LOCK_OK, 1);
        check("lost_t1_flag", LOCK_LOST, 0);
        @(negedge PCLK);
        check("lost_t2_lock_ok", LOCK_OK, 0);
        @(negedge PCLK);
        check("lost_t3_flag", LOCK_LOST, 1);
        CCC_LOCK = 1'b1;
        repeat (4) @(negedge PCLK);
        check("lost_sticky", LOCK_LOST, 1);
        check("lost_relock", LOCK_OK, 1);
        run_vec(6, mk(1, 3, 0, 0, 0, 28, 1, 0, 0, 1, 1, 21, 1, 17));

        // Reset in the access phase of the first write.
        CCC_LOCK = 1'b0; TBL_COUNT = 4'd3; START = 1'b1;
        @(negedge PCLK);
        START = 1'b0;
        repeat (17) @(negedge PCLK);
        check("rst_mid_in_write", {PSEL, PENABLE, PWRITE, PLL_ARST_N}, 4'b1110);
        PRESET_N = 1'b0;
        @(negedge PCLK);
        check("rst_mid_outputs", out_snapshot(), 32'h1);
        PRESET_N = 1'b1;
        @(negedge PCLK);
        $display("reset mid-write applied");

        // The table is cleared by reset, so a one-entry run writes address 0 with data 0.
        for (int i = 0; i < NE; i++) begin
            exp_addr[i] = 6'h00;
            exp_data[i] = 8'h00;
        end
        run_vec(7, mk(1, 3, 0, 0, 0, 28, 1, 0, 0, 1, 1, 21, 1, 17));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ccc_reconfig_ctrl.md
# ccc_reconfig_ctrl

Sequencer for dynamic reconfiguration of the fabric CCC/PLL through its APB configuration port. A host loads a small table of (register address, data) pairs and pulses START. The block then holds the PLL in reset, writes each entry over APB with optional read-back verify, releases reset, and waits for LOCK with timeout and bounded retry. It sits between the system controller and the CCC instance, and also monitors for loss of lock.

## Interface
- NUM_ENTRIES, 8: table depth (≥1)
- RST_CYCLES, 16: minimum PLL_ARST_N low cycles before the first APB write
- LOCK_TIMEOUT, 65535: PCLK cycles allowed for LOCK after reset release (≥4)
- MAX_RETRIES, 2: additional reset/lock attempts after a lock timeout
- VERIFY, 1: 1 = read back and compare every written entry

Ports (IW = clog2(NUM_ENTRIES), CW = clog2(NUM_ENTRIES+1)):
- PCLK  in  1  single clock for the whole block
- PRESET_N  in  1  synchronous, active-low reset
- TBL_WE  in  1  table write strobe
- TBL_IDX  in  IW  table entry index
- TBL_ADDR  in  6  CCC register address
- TBL_DATA  in  8  CCC register data
- TBL_COUNT  in  CW  number of entries to apply; sampled on an accepted START
- START  in  1  single-cycle start request
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle pulse on successful completion
- ERROR  out  1  sticky failure flag
- ERR_CODE  out  2  00 none, 01 verify mismatch, 10 lock timeout
- LOCK_OK  out  1  synchronized CCC lock
- LOCK_LOST  out  1  sticky: lock fell while idle
- PSEL, PENABLE, PWRITE  out  1 each  APB control to the CCC
- PADDR  out  6  APB address
- PWDATA  out  8  APB write data
- PRDATA  in  8  APB read data
- CCC_LOCK  in  1  raw PLL lock, asynchronous to PCLK
- PLL_ARST_N  out  1  PLL reset, active-low

## Operation
- Reset values: all outputs 0 except PLL_ARST_N = 1. Table entries, retry counter and timers are cleared to 0. FSM = IDLE.
- CCC_LOCK passes through a 2-flop synchronizer. LOCK_OK is the second flop.
- Table writes are accepted only when BUSY = 0. TBL_WE while BUSY is ignored.
- START is accepted only in IDLE. START while BUSY is ignored. An accepted START clears ERROR, ERR_CODE and LOCK_LOST, latches TBL_COUNT (values > NUM_ENTRIES saturate to NUM_ENTRIES), and zeroes the entry and retry counters.
- FSM states:
  - IDLE → RST_HOLD on accepted START.
  - RST_HOLD: PLL_ARST_N = 0 for RST_CYCLES cycles. Then go to W_SETUP if the count is > 0, otherwise to RELEASE.
  - W_SETUP: PSEL = 1, PWRITE = 1, PENABLE = 0, PADDR/PWDATA = current entry.
  - W_ACCESS: PENABLE = 1. Next state is R_SETUP if VERIFY, else NEXT.
  - R_SETUP / R_ACCESS: PWRITE = 0, same PADDR. PRDATA is compared with the entry data at the end of R_ACCESS. On mismatch, set ERR_CODE = 01 and go to FAIL. On match, go to NEXT.
  - NEXT: increment the entry index. Go to W_SETUP if entries remain, else RELEASE.
  - RELEASE: PLL_ARST_N = 1 and the lock timer is cleared. Go to WAIT_LOCK.
  - WAIT_LOCK: the timer increments each cycle. LOCK_OK = 1 goes to SUCCESS. Timer == LOCK_TIMEOUT with LOCK_OK = 0 is a timeout: if retry counter < MAX_RETRIES, increment it and go to RST_HOLD (the table is re-applied); otherwise set ERR_CODE = 10 and go to FAIL.
  - SUCCESS: DONE = 1 for one cycle, then IDLE.
  - FAIL: ERROR = 1, PLL_ARST_N = 1. Go to IDLE.
- PLL_ARST_N stays low continuously from RST_HOLD through the last NEXT.
- APB is zero-wait-state (the CCC has no PREADY). Every transfer is exactly one setup cycle plus one access cycle. PSEL/PENABLE are 0 outside transfers. PADDR/PWDATA hold their last value.
- LOCK_LOST is set when LOCK_OK goes 1→0 while the FSM is IDLE. Lock drops during BUSY are expected and not flagged.
- PRESET_N low mid-sequence aborts immediately to the reset values. This means PLL_ARST_N returns to 1 and the CCC keeps whatever registers were already written.

## Timing
- START sampled in cycle 0. BUSY = 1 and PLL_ARST_N = 0 from cycle 1.
- First PSEL = 1 at cycle 1 + RST_CYCLES.
- Each entry takes 2 cycles with VERIFY = 0 and 4 with VERIFY = 1, plus 1 NEXT cycle.
- LOCK_OK lags CCC_LOCK by 2 PCLK cycles.
- DONE pulses the cycle after LOCK_OK is seen in WAIT_LOCK. BUSY falls in the same cycle as DONE or ERROR rises.
- ERROR/ERR_CODE stay valid until the next accepted START or reset.

## Test plan
- Load 3 entries, VERIFY = 1, PRDATA echoes writes, CCC_LOCK rises 10 cycles after release → expect 3 write/read pairs with correct PADDR/PWDATA, PLL_ARST_N low throughout the writes, DONE pulse, ERROR = 0.
- Entry 1 read-back returns data XOR 0x01 → expect ERR_CODE = 01, ERROR = 1, no write to entry 2, PLL_ARST_N = 1, BUSY = 0.
- CCC_LOCK held 0, LOCK_TIMEOUT = 100, MAX_RETRIES = 2 → expect 3 full RST_HOLD + write passes, then ERR_CODE = 10 and ERROR = 1.
- TBL_COUNT = 0 → expect no PSEL activity, PLL_ARST_N low for exactly RST_CYCLES, DONE after lock.
- START and TBL_WE during BUSY → expect both ignored; the table is unchanged on the next run.
- Idle with LOCK_OK = 1, CCC_LOCK drops → LOCK_LOST = 1 after 2–3 cycles. The next START clears it. PRESET_N low mid-write → all outputs return to reset values the next cycle.
